// File: rtl/rr_pkg.sv
// Shared constants and state type for the round-robin grant controller.
package rr_pkg;

  localparam int N         = 8;
  localparam int IDX_W     = 3;
  localparam int DWELL_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_grant_ctrl_pick8.sv
// Combinational circular picker: first set request at or after ptr, wrapping 7->0.
module rr_pick8
  import rr_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_any
);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;

  always_comb begin
    // rotate right so the search start lands on bit 0
    w_rot = (req >> ptr) | (req << (4'd8 - {1'b0, ptr}));
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
    pick_idx = w_off + ptr;
    pick_any = |req;
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter for eight requesters; one registered one-hot grant at a time.
// Optional dwell timeout compiled in with `define RR_DWELL_TIMEOUT_EN.
module rr_grant_ctrl
  import rr_pkg::*;
#(
  parameter int N     = rr_pkg::N,
  parameter int IDX_W = rr_pkg::IDX_W,
  parameter int DWELL = rr_pkg::DWELL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] ptr
);

  if (DWELL < 2 || DWELL > 255) begin : g_dwell_range
    $error("rr_grant_ctrl: DWELL must be in 2..255");
  end

  rr_state_t        r_state, w_state_nxt;
  logic [N-1:0]     r_grant, w_grant_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
  logic             w_release;
  logic             w_timeout;

  rr_pick8 u_pick (
    .req      (req),
    .ptr      (r_ptr),
    .pick_idx (w_pick_idx),
    .pick_any (w_pick_any)
  );

  assign w_release = ~req[r_gnt_idx];

`ifdef RR_DWELL_TIMEOUT_EN
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  logic [7:0] r_dwell, w_dwell_nxt;
  logic       w_dwell_end;
  logic       w_others;

  assign w_dwell_end = (r_dwell == DWELL_LAST);
  assign w_others    = |(req & ~r_grant);
  assign w_timeout   = w_dwell_end & w_others;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dwell <= 8'd0;
    else        r_dwell <= w_dwell_nxt;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en && w_pick_any) w_state_nxt = GRANT;
      GRANT:   if (!en || w_release || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt     = r_grant;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_ptr_nxt       = r_ptr;
`ifdef RR_DWELL_TIMEOUT_EN
    w_dwell_nxt     = r_dwell;
`endif
    case (r_state)
      IDLE: begin
        if (en && w_pick_any) begin
          w_grant_nxt     = N'(1) << w_pick_idx;
          w_gnt_idx_nxt   = w_pick_idx;
          w_gnt_valid_nxt = 1'b1;
`ifdef RR_DWELL_TIMEOUT_EN
          w_dwell_nxt     = 8'd0;
`endif
        end
      end
      GRANT: begin
        // en=0 drops the grant without advancing the pointer
        if (!en || w_release || w_timeout) begin
          w_grant_nxt     = '0;
          w_gnt_idx_nxt   = '0;
          w_gnt_valid_nxt = 1'b0;
          if (en) w_ptr_nxt = r_gnt_idx + 1'b1;
        end else begin
`ifdef RR_DWELL_TIMEOUT_EN
          w_dwell_nxt = w_dwell_end ? 8'd0 : r_dwell + 8'd1;
`endif
        end
      end
      default: begin
        w_grant_nxt     = '0;
        w_gnt_idx_nxt   = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  assign grant     = r_grant;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign ptr       = r_ptr;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl with hand-computed expectations.
module tb_rr_grant_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       en;
  logic [7:0] grant;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [2:0] ptr;

  int n_total = 0;
  int n_bad   = 0;

  rr_grant_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .en        (en),
    .grant     (grant),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [2:0] exp_ptr);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_valid"}, gnt_valid, 0);
    chk({tag, "_idx"}, gnt_idx, 0);
    chk({tag, "_ptr"}, ptr, exp_ptr);
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] exp_idx);
    logic [7:0] oh;
    oh = 8'd1 << exp_idx;
    chk({tag, "_grant"}, grant, oh);
    chk({tag, "_idx"}, gnt_idx, exp_idx);
    chk({tag, "_valid"}, gnt_valid, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    req   = 8'h00;
    #1 rst_n = 1'b0;
    step();
    chk_idle("reset", 3'd0);
    step();
    rst_n = 1'b1;
    step();
    chk_idle("noreq0", 3'd0);
    step();
    chk_idle("noreq1", 3'd0);

    req = 8'b0010_0100;
    step();
    chk_gnt("first", 3'd2);
    chk("first_ptr", ptr, 0);

    // rotation: drop holder 2
    req = 8'b0010_0000;
    step();
    chk_idle("rot_gap", 3'd3);
    step();
    chk_gnt("rot", 3'd5);

    // holder 5 drops, 7 picked from ptr 6
    req = 8'b1000_0001;
    step();
    chk_idle("to7_gap", 3'd6);
    step();
    chk_gnt("hold7", 3'd7);

    // wrap-around
    req = 8'b0000_0001;
    step();
    chk_idle("wrap_gap", 3'd0);
    step();
    chk_gnt("wrap", 3'd0);

    req = 8'b0001_0000;
    step();
    chk_idle("to4_gap", 3'd1);
    step();
    chk_gnt("hold4", 3'd4);

    // enable kill keeps pointer
    en = 1'b0;
    step();
    chk_idle("kill", 3'd1);
    step();
    chk_idle("kill_hold", 3'd1);
    en = 1'b1;
    step();
    chk_gnt("regrant4", 3'd4);

    // en=0 and holder drop on same edge: en wins, ptr unchanged
    en  = 1'b0;
    req = 8'b0000_0000;
    step();
    chk_idle("en_wins", 3'd1);
    en = 1'b1;
    step();
    chk_idle("en_back_noreq", 3'd1);

    req = 8'b0000_0011;
    step();
    chk_gnt("pair1", 3'd1);
`ifdef RR_DWELL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    chk_gnt("dwell1_last", 3'd1);
    step();
    chk_idle("dwell1_gap", 3'd2);
    step();
    chk_gnt("dwell0_first", 3'd0);
    for (int i = 0; i < 15; i++) step();
    chk_gnt("dwell0_last", 3'd0);
    step();
    chk_idle("dwell0_gap", 3'd1);
    step();
    chk_gnt("dwell1_again", 3'd1);
`else
    for (int i = 0; i < 40; i++) step();
    chk_gnt("nodwell_hold", 3'd1);
`endif

    // lone requester is held indefinitely
    req = 8'b0000_0001;
    step();
    chk_idle("solo_gap", 3'd2);
    step();
    chk_gnt("solo", 3'd0);
    for (int i = 0; i < 40; i++) step();
    chk_gnt("solo_hold", 3'd0);
    chk("solo_ptr", ptr, 2);

    // async reset between edges
    #2 rst_n = 1'b0;
    req = 8'b0000_0110;
    #1;
    chk_idle("async_rst", 3'd0);
    #1 rst_n = 1'b1;
    step();
    chk_gnt("after_rst", 3'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter that shares the single 8-to-3 encoder and HEX0 seven-segment display among eight requesters (SW0–SW7). It holds one grant at a time and rotates fairly, instead of fixed priority. Its one-hot `grant` drives the encoder's `x` input, `gnt_valid` drives the encoder enable, and `gnt_idx` mirrors the encoded index for the LEDs.

## Interface
- `N`, 8, number of requesters (fixed at 8 in this design; widths derive from it)
- `IDX_W`, 3, index width, log2(N)
- `DWELL`, 16, maximum cycles a grant is held while others wait (range 2..255)

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req`  in  N  level request per requester; bit i = SWi
- `en`  in  1  arbiter enable (SW8); low forces release and idle
- `grant`  out  N  one-hot grant, all-zero when idle
- `gnt_idx`  out  IDX_W  index of granted requester, 0 when idle
- `gnt_valid`  out  1  high while a grant is held
- `ptr`  out  IDX_W  current round-robin search start, for debug display

## Operation
- State machine has two states, `IDLE` and `GRANT`. Reset puts it in `IDLE` with `ptr`=0, `grant`=0, `gnt_idx`=0, `gnt_valid`=0, and dwell counter 0.
- **IDLE:**
  - If `en` and |`req`, pick the first set bit at or after `ptr`, searching circularly (wrapping 7→0).
  - Register that pick into `grant`/`gnt_idx`, set `gnt_valid`, go to `GRANT`, and clear the dwell counter.
  - Otherwise stay in `IDLE`.
- **GRANT**, conditions evaluated in priority order:
  1. `en`=0: clear all outputs and go to `IDLE`. `ptr` is unchanged.
  2. `req[gnt_idx]`=0 (holder released): set `ptr` = `gnt_idx`+1 mod 8, go to `IDLE`, clear outputs.
  3. Dwell timeout (see Configuration): set `ptr` = `gnt_idx`+1 mod 8, go to `IDLE`, clear outputs.
  4. Otherwise hold the grant and increment the dwell counter.
- Every release passes through `IDLE` for exactly one cycle, so `grant` is all-zero for at least one cycle between two different holders.
- Pointer wrap: releasing index 7 sets `ptr`=0.
- A requester that drops and re-raises its request while not granted waits its normal turn. No request is latched.
- `grant` never has more than one bit set. `gnt_idx` always equals the encoding of `grant`.

## Timing
- All outputs are registered. Nothing is combinational from `req`/`en` to any output.
- Grant latency: a request sampled at edge k in `IDLE` (with `en`=1) makes `grant` visible after edge k.
- Release latency: a request drop sampled at edge k makes `grant`=0 after edge k. The next grant appears after edge k+1 at the earliest.
- Deasserting `rst_n` mid-grant clears all outputs immediately (asynchronously). On the first edge after reset is released, arbitration restarts from `ptr`=0.
- If `en` and `req` change on the same edge, `en`=0 wins.

## Configuration
- `RR_DWELL_TIMEOUT_EN` defined:
  - The dwell counter (8 bits) is compiled in.
  - In `GRANT`, when the counter equals `DWELL`-1 and any other `req` bit is set, the grant is force-released (condition 3).
  - If no other requester is pending at that point, the counter resets to 0 and the grant is kept.
- `RR_DWELL_TIMEOUT_EN` undefined:
  - The counter and condition 3 are absent.
  - A grant is held until the holder's `req` drops or `en` falls.

## Structure
- Package `rr_pkg` holds:
  - `N` and `IDX_W` constants
  - the state enum `rr_state_t` {`IDLE`, `GRANT`}
  - the default `DWELL` value
- Sub-module `rr_pick8` is a purely combinational circular picker.
  - Inputs: `req`[7:0] and `ptr`[2:0].
  - Outputs: `pick_idx`[2:0] and `pick_any`.
  - Method: rotate `req` right by `ptr`, take the lowest set bit, then add `ptr` mod 8.
- The top level `rr_grant_ctrl` contains only the FSM, the pointer register, the dwell counter and the output registers.

## Test plan
- **Reset and first grant:** `rst_n`=0 then 1, with `en`=1 and `req`=8'b0000_0000 → outputs stay 0. Then set `req`=8'b0010_0100 → after 1 edge `grant`=8'b0000_0100, `gnt_idx`=2, `gnt_valid`=1.
- **Rotation:** with `req`=8'b0010_0100 granted to 2, drop bit 2 → one idle cycle with `ptr`=3, then `grant`=8'b0010_0000, `gnt_idx`=5.
- **Wrap-around:** requester 7 holds the grant and `req`=8'b1000_0001. Drop bit 7 → `ptr`=0, next `gnt_idx`=0.
- **Enable kill:** mid-grant to index 4, drive `en`=0 → `grant`=0 and `gnt_valid`=0 after 1 edge, and `ptr` is unchanged. Re-assert `en` → index 4 is re-granted if its request is still high.
- **Dwell (macro defined, `DWELL`=16):** `req`=8'b0000_0011 held constant → `gnt_idx` alternates 0,1,0,… Each grant lasts exactly 16 cycles, separated by one idle cycle. With `req`=8'b0000_0001 only, index 0 is held indefinitely.
- **Async reset mid-grant:** pulse `rst_n` low between edges while `gnt_valid`=1 → all outputs go to 0 before the next edge, and `ptr`=0.
